// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, functs, ALU codes,
// FSM state encoding, mux select encodings and the per-state control word decode.
// Pure declarations; no logic of its own.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Coarse ALU operation chosen by the FSM; FUNCT defers to the funct field.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore part of the control word. pcwrite/branch/fetch are qualifiers that the
    // top combines with zero and mem_ready to form pc_en and irwrite.
    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       memtoreg;
        logic       regdst;
        logic       memwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
        logic       fetch;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        c.aluop = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.alusrcb = SRCB_FOUR;
                c.fetch   = 1'b1;
            end
            S_DECODE: c.alusrcb = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_RTEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REGB;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REGB;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.branch  = 1'b1;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            default: c.aluop = ALUOP_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps aluop/funct to the 3-bit ALU control code and flags legal functs.
// Latency: purely combinational.
// Backpressure: none; consumers sample it when they need it.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_legal
);

    logic [2:0] fn_code;

    // Funct-field lookup; the legal flag is independent of aluop so DECODE can use it.
    always_comb begin
        fn_code     = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  fn_code = ALU_ADD;
            FN_SUB:  fn_code = ALU_SUB;
            FN_AND:  fn_code = ALU_AND;
            FN_OR:   fn_code = ALU_OR;
            FN_SLT:  fn_code = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    // Select between the FSM-forced operations and the funct-derived one.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = fn_code;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with retired-instruction counter.
// Latency: lw 5, sw 4, R-type/addi 4, beq/j 3 cycles with zero-wait memory.
// Backpressure: FETCH, MEMRD and MEMWR stall on mem_ready when MEM_HS=1.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int MEM_HS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             memtoreg,
    output logic             regdst,
    output logic             irwrite,
    output logic             pc_en,
    output logic             memwrite,
    output logic             regwrite,
    output logic [2:0]       alucontrol,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [2:0]       alucontrol_q, alucontrol_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_ok;
    logic             funct_legal;
    logic             op_illegal;
    logic             retire;

    assign mem_ok = (MEM_HS != 0) ? mem_ready : 1'b1;

    // ALU code for the upcoming state; funct is stable since IR only loads in FETCH.
    alu_decoder u_alu_decoder (
        .aluop       (ctrl_d.aluop),
        .funct       (funct),
        .alucontrol  (alucontrol_d),
        .funct_legal (funct_legal)
    );

    // Opcode/funct legality, only meaningful while in DECODE.
    always_comb begin
        op_illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
            OP_RTYPE: op_illegal = ~funct_legal;
            default:  op_illegal = 1'b1;
        endcase
    end

    // Next-state logic; unused codes fall back to FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                if (op_illegal) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_RTEX;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ok) state_d = S_FETCH;
            S_RTEX:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control word for the next state, so the Moore outputs come straight from flops.
    always_comb begin
        ctrl_d = decode_state(state_d);
    end

    // An instruction retires on its final transition back into FETCH.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = mem_ok;
            default: retire = 1'b0;
        endcase
        retired_d = retired_q + (retire ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}});
    end

    // FSM state, registered control word and counter; reset aborts any instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            ctrl_q       <= decode_state(S_FETCH);
            alucontrol_q <= ALU_ADD;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            alucontrol_q <= alucontrol_d;
            retired_q    <= retired_d;
        end
    end

    assign iord       = ctrl_q.iord;
    assign alusrca    = ctrl_q.alusrca;
    assign alusrcb    = ctrl_q.alusrcb;
    assign pcsrc      = ctrl_q.pcsrc;
    assign memtoreg   = ctrl_q.memtoreg;
    assign regdst     = ctrl_q.regdst;
    assign memwrite   = ctrl_q.memwrite & ~reset;
    assign regwrite   = ctrl_q.regwrite & ~reset;
    assign alucontrol = alucontrol_q;
    assign state_dbg  = state_q;
    assign retired    = retired_q;

    // Handshake- and flag-dependent enables are gated by reset so nothing fires while held.
    assign irwrite    = ~reset & ctrl_q.fetch & mem_ok;
    assign pc_en      = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero) | (ctrl_q.fetch & mem_ok));
    assign illegal_op = ~reset & (state_q == S_DECODE) & op_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Every comparison goes through the check task.
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        iord;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    logic        memtoreg;
    logic        regdst;
    logic        irwrite;
    logic        pc_en;
    logic        memwrite;
    logic        regwrite;
    logic [2:0]  alucontrol;
    logic        illegal_op;
    logic [3:0]  state_dbg;
    logic [31:0] retired;

    int n_chk;
    int n_err;
    int wr_cycles;

    mips_multicycle_ctrl #(.CNT_W(32), .MEM_HS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .irwrite    (irwrite),
        .pc_en      (pc_en),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .alucontrol (alucontrol),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        opcode = 6'b100011;
        funct = 6'b000000;
        zero = 1'b0;
        mem_ready = 1'b1;
        repeat (2) step();

        // Reset held: FETCH, counter 0, enables forced off despite mem_ready=1
        check("rst_state", state_dbg, 0);
        check("rst_retired", retired, 0);
        check("rst_irwrite", irwrite, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_regwrite", regwrite, 0);

        // lw, zero-wait: 0,1,2,3,4,0
        reset = 1'b0;
        #1;
        check("lw_f_state", state_dbg, 0);
        check("lw_f_irwrite", irwrite, 1);
        check("lw_f_pc_en", pc_en, 1);
        check("lw_f_srcb", alusrcb, 2'b01);
        check("lw_f_alu", alucontrol, 3'b010);
        step();
        check("lw_d_state", state_dbg, 1);
        check("lw_d_srcb", alusrcb, 2'b11);
        check("lw_d_irwrite", irwrite, 0);
        step();
        check("lw_a_state", state_dbg, 2);
        check("lw_a_srca", alusrca, 1);
        check("lw_a_srcb", alusrcb, 2'b10);
        check("lw_a_regwrite", regwrite, 0);
        step();
        check("lw_r_state", state_dbg, 3);
        check("lw_r_iord", iord, 1);
        check("lw_r_regwrite", regwrite, 0);
        step();
        check("lw_wb_state", state_dbg, 4);
        check("lw_wb_regwrite", regwrite, 1);
        check("lw_wb_memtoreg", memtoreg, 1);
        check("lw_wb_regdst", regdst, 0);
        check("lw_wb_retired", retired, 0);
        step();
        check("lw_end_state", state_dbg, 0);
        check("lw_end_regwrite", regwrite, 0);
        check("lw_end_retired", retired, 1);

        // R-type sub: 0,1,6,7,0
        opcode = 6'b000000;
        funct = 6'b100010;
        step();
        check("sub_d_state", state_dbg, 1);
        check("sub_d_illegal", illegal_op, 0);
        step();
        check("sub_ex_state", state_dbg, 6);
        check("sub_ex_alu", alucontrol, 3'b110);
        check("sub_ex_srcb", alusrcb, 2'b00);
        check("sub_ex_srca", alusrca, 1);
        step();
        check("sub_wb_state", state_dbg, 7);
        check("sub_wb_regdst", regdst, 1);
        check("sub_wb_regwrite", regwrite, 1);
        check("sub_wb_memtoreg", memtoreg, 0);
        step();
        check("sub_end_state", state_dbg, 0);
        check("sub_end_retired", retired, 2);

        // R-type slt: funct-driven ALU code
        funct = 6'b101010;
        step();
        step();
        check("slt_ex_alu", alucontrol, 3'b111);
        step();
        step();
        check("slt_end_retired", retired, 3);

        // beq taken then not taken
        opcode = 6'b000100;
        zero = 1'b1;
        step();
        step();
        check("beq1_state", state_dbg, 8);
        check("beq1_pc_en", pc_en, 1);
        check("beq1_pcsrc", pcsrc, 2'b01);
        check("beq1_alu", alucontrol, 3'b110);
        step();
        check("beq1_end_state", state_dbg, 0);
        zero = 1'b0;
        step();
        step();
        check("beq2_state", state_dbg, 8);
        check("beq2_pc_en", pc_en, 0);
        step();
        check("beq2_retired", retired, 5);

        // sw with mem_ready low for 3 cycles in MEMWR
        opcode = 6'b101011;
        step();
        step();
        check("sw_a_state", state_dbg, 2);
        mem_ready = 1'b0;
        wr_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sw_wait_state", state_dbg, 5);
            if (memwrite === 1'b1) wr_cycles++;
        end
        mem_ready = 1'b1;
        #1;
        check("sw_last_state", state_dbg, 5);
        check("sw_last_iord", iord, 1);
        if (memwrite === 1'b1) wr_cycles++;
        check("sw_last_retired", retired, 5);
        step();
        check("sw_wr_cycles", wr_cycles, 4);
        check("sw_end_state", state_dbg, 0);
        check("sw_end_memwrite", memwrite, 0);
        check("sw_end_retired", retired, 6);

        // FETCH stall for 2 cycles, then an illegal opcode in DECODE
        opcode = 6'b111111;
        mem_ready = 1'b0;
        #1;
        check("fst0_irwrite", irwrite, 0);
        check("fst0_pc_en", pc_en, 0);
        step();
        check("fst1_state", state_dbg, 0);
        check("fst1_irwrite", irwrite, 0);
        check("fst1_pc_en", pc_en, 0);
        step();
        check("fst2_state", state_dbg, 0);
        mem_ready = 1'b1;
        #1;
        check("fst2_irwrite", irwrite, 1);
        check("fst2_pc_en", pc_en, 1);
        step();
        check("ill_state", state_dbg, 1);
        check("ill_flag", illegal_op, 1);
        step();
        check("ill_end_state", state_dbg, 0);
        check("ill_end_flag", illegal_op, 0);
        check("ill_end_retired", retired, 6);

        // Illegal funct under R-type opcode
        opcode = 6'b000000;
        funct = 6'b000000;
        step();
        check("illfn_flag", illegal_op, 1);
        step();
        check("illfn_end_state", state_dbg, 0);
        check("illfn_retired", retired, 6);

        // addi: 0,1,9,10,0
        opcode = 6'b001000;
        step();
        step();
        check("addi_ex_state", state_dbg, 9);
        check("addi_ex_srcb", alusrcb, 2'b10);
        step();
        check("addi_wb_state", state_dbg, 10);
        check("addi_wb_regwrite", regwrite, 1);
        check("addi_wb_regdst", regdst, 0);
        step();
        check("addi_retired", retired, 7);

        // jump: 0,1,11,0
        opcode = 6'b000010;
        step();
        step();
        check("j_state", state_dbg, 11);
        check("j_pc_en", pc_en, 1);
        check("j_pcsrc", pcsrc, 2'b10);
        step();
        check("j_retired", retired, 8);

        // Reset asserted in MEMRD
        opcode = 6'b100011;
        step();
        step();
        step();
        check("rmr_state_pre", state_dbg, 3);
        reset = 1'b1;
        #1;
        check("rmr_state", state_dbg, 0);
        check("rmr_irwrite", irwrite, 0);
        check("rmr_pc_en", pc_en, 0);
        check("rmr_memwrite", memwrite, 0);
        check("rmr_regwrite", regwrite, 0);
        check("rmr_iord", iord, 0);
        check("rmr_retired", retired, 0);
        step();
        reset = 1'b0;
        #1;
        check("rel_state", state_dbg, 0);
        check("rel_irwrite", irwrite, 1);
        step();
        check("rel_d_state", state_dbg, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Safety bound: the directed sequence finishes far earlier than this.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000ns");
        $fatal(1);
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Each cycle it drives every 2:1 and 4:1 datapath mux select, all register and memory enables, and the ALU control code.
- Tracks memory handshakes and counts retired instructions.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- MEM_HS, 1: 1 = wait on mem_ready in memory states; 0 = every memory access completes in one cycle (mem_ready ignored).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns FSM to FETCH.
- opcode  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- iord  out  1  address mux select: 0 = PC, 1 = ALUOut.
- alusrca  out  1  ALU A mux: 0 = PC, 1 = reg A.
- alusrcb  out  2  ALU B mux: 00 = reg B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- pcsrc  out  2  PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- memtoreg  out  1  writeback mux: 0 = ALUOut, 1 = data reg.
- regdst  out  1  dest mux: 0 = rt, 1 = rd.
- irwrite  out  1  IR load enable.
- pc_en  out  1  PC load enable (pcwrite OR (branch AND zero)).
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write enable.
- alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- illegal_op  out  1  one-cycle flag for unsupported opcode/funct.
- state_dbg  out  4  current state encoding.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Outputs are Moore (decoded from state). Exceptions, all combinational:
  - pc_en depends on zero in BRANCH and on mem_ready in FETCH.
  - irwrite depends on mem_ready in FETCH.
  - illegal_op depends on opcode/funct in DECODE.
- Default for any output not listed for a state: 0; alucontrol defaults to 010.
- Reset:
  - While reset is high, state = FETCH, retired = 0, and all enables (irwrite, pc_en, memwrite, regwrite) and illegal_op are forced to 0.
  - Reset mid-instruction aborts it with no counter increment.
- State encoding (4 bits): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12..15 go to FETCH.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010.
  - irwrite = pc_en = mem_ready (or 1 if MEM_HS=0).
  - Advance to DECODE only when ready; otherwise stay.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut).
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> RTEX; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode, or opcode 000000 with funct not in {100000, 100010, 100100, 100101, 101010}: illegal_op=1 and -> FETCH, no increment.
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Stay until mem_ready, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. -> FETCH.
- MEMWR: iord=1, memwrite=1, held until mem_ready, then -> FETCH.
- RTEX:
  - Outputs: alusrca=1, alusrcb=00.
  - alucontrol by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pc_en=zero. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. -> FETCH.
- JUMP: pcsrc=10, pc_en=1. -> FETCH.
- Retired counter:
  - Increments by 1 on the transition into FETCH from MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, and from MEMWR on its completing cycle.
  - Wraps modulo 2^CNT_W.
- Latencies (cycles, zero-wait memory): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- opcode/funct are sampled only in DECODE, RTEX and MEMADR; the IR is stable because irwrite=0 outside FETCH.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J).
  - Funct constants.
  - ALU control codes.
  - State encoding constants.
  - Mux select encodings for alusrcb and pcsrc.
- One natural sub-module: alu_decoder (combinational funct/aluop -> alucontrol plus funct-legal flag), reused by the pipelined variant.
- FSM, output decode and counter stay in mips_multicycle_ctrl.

Test Plan:
- Reset, then deassert with opcode=100011 and mem_ready=1 throughout:
  - state_dbg sequence 0,1,2,3,4,0.
  - regwrite=1 only in state 4 with memtoreg=1.
  - retired 0 -> 1.
- R-type sub (opcode 0, funct 100010):
  - RTEX shows alucontrol=110, alusrcb=00.
  - ALUWB shows regdst=1, regwrite=1.
  - Total 4 cycles.
- beq twice:
  - zero=1: pc_en=1 with pcsrc=01 in BRANCH.
  - zero=0: pc_en=0.
  - Both retire; retired increments by 2.
- sw with mem_ready low for 3 cycles in MEMWR:
  - memwrite held 4 cycles.
  - FSM leaves to FETCH only on the mem_ready cycle.
  - Exactly one increment.
- FETCH with mem_ready=0 for 2 cycles:
  - irwrite = pc_en = 0 and state stays 0.
  - Third cycle mem_ready=1: both 1, then DECODE.
- opcode 111111 in DECODE:
  - illegal_op=1 for one cycle, back to FETCH, retired unchanged.
- Assert reset during MEMRD:
  - Immediately state_dbg=0 and all enables 0.
  - Release reset: normal fetch resumes.
